// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// datapath width, divider iteration count and two's complement helpers.
package mdu_pkg;

  localparam int XLEN       = 32;
  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Two's complement negation of a full-width value.
  function automatic logic [XLEN-1:0] neg_val(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of v when treated as signed, otherwise v unchanged.
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    logic [XLEN-1:0] r;
    if (is_signed && v[XLEN-1]) begin
      r = neg_val(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-side request/response bundle between the pipeline and the multiply/divide unit.
interface mul_div_unit_if;
  import mdu_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            cancel;
  logic            busy;
  logic            done;
  logic [1:0]      hi_wen;
  logic [1:0]      lo_wen;
  logic [XLEN-1:0] hi_wdata;
  logic [XLEN-1:0] lo_wdata;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, done, hi_wen, lo_wen, hi_wdata, lo_wdata
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, done, hi_wen, lo_wen, hi_wdata, lo_wdata
  );

endinterface

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per step, the dividend
// shifts out of the quotient register as quotient bits shift in.
module div_core
  import mdu_pkg::*;
#(
  parameter int W      = XLEN,
  parameter int CYCLES = mdu_pkg::DIV_CYCLES
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o,
  output logic         last_o
);

  localparam int CW = $clog2(CYCLES);

  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    rem_sh_s;
  logic [W:0]    diff_s;

  // Load operands, or perform one shift-subtract-restore step on the 33-bit partial remainder.
  always_comb begin
    rem_sh_s = {rem_q, quot_q[W-1]};
    diff_s   = rem_sh_s - {1'b0, dvs_q};
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      quot_d = dividend_i;
      rem_d  = {W{1'b0}};
      dvs_d  = divisor_i;
      cnt_d  = {CW{1'b0}};
    end else if (step_i) begin
      if (!diff_s[W]) begin
        rem_d  = diff_s[W-1:0];
        quot_d = {quot_q[W-2:0], 1'b1};
      end else begin
        rem_d  = rem_sh_s[W-1:0];
        quot_d = {quot_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quot_q <= {W{1'b0}};
      rem_q  <= {W{1'b0}};
      dvs_q  <= {W{1'b0}};
      cnt_q  <= {CW{1'b0}};
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign last_o = (cnt_q == CW'(CYCLES - 1));

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO producer: MULT/MULTU in one compute cycle, DIV/DIVU through the
// iterative divider, with sign handling and registered HI/LO write port.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int DIV_CYCLES = mdu_pkg::DIV_CYCLES
) (
  input  logic          clk,
  input  logic          resetn,
  mul_div_unit_if.slave bus
);

  localparam int DW = DATA_WIDTH;

  state_e          state_q, state_d;
  logic [1:0]      op_q;
  logic [DW-1:0]   a_q, b_q;
  logic [2*DW-1:0] a_ext_s, b_ext_s, prod_s, prod_q;
  logic            accept_s, wr_s, div_load_s, div_step_s, div_last_s;
  logic [DW-1:0]   dvd_s, dvs_s, quot_s, rem_s, hi_res_s, lo_res_s;
  logic            busy_q, done_q;
  logic [1:0]      hi_wen_q, lo_wen_q;
  logic [DW-1:0]   hi_q, lo_q;

  // busy_q also covers the output cycle, when the FSM is already back in IDLE.
  assign accept_s   = (state_q == ST_IDLE) && !busy_q && bus.start && !bus.cancel;
  assign div_load_s = accept_s && bus.op[1];
  assign div_step_s = (state_q == ST_DIV) && !bus.cancel;
  assign wr_s       = (state_q == ST_DONE) && !bus.cancel;
  assign dvd_s      = abs_val(bus.src_a, bus.op == OP_DIV);
  assign dvs_s      = abs_val(bus.src_b, bus.op == OP_DIV);

  div_core #(.W(DW), .CYCLES(DIV_CYCLES)) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (div_load_s),
    .step_i     (div_step_s),
    .dividend_i (dvd_s),
    .divisor_i  (dvs_s),
    .quot_o     (quot_s),
    .rem_o      (rem_s),
    .last_o     (div_last_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch op and raw operands on acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q <= 2'b00;
      a_q  <= {DW{1'b0}};
      b_q  <= {DW{1'b0}};
    end else if (accept_s) begin
      op_q <= bus.op;
      a_q  <= bus.src_a;
      b_q  <= bus.src_b;
    end
  end

  // Sign- or zero-extend to 64 bits so one multiplier serves both MULT and MULTU.
  always_comb begin
    a_ext_s = {{DW{(op_q == OP_MULT) & a_q[DW-1]}}, a_q};
    b_ext_s = {{DW{(op_q == OP_MULT) & b_q[DW-1]}}, b_q};
    prod_s  = a_ext_s * b_ext_s;
  end

  // Product register, loaded during the MUL cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prod_q <= {(2*DW){1'b0}};
    end else if (state_q == ST_MUL) begin
      prod_q <= prod_s;
    end
  end

  // Next-state logic; cancel returns to IDLE from any active state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = bus.op[1] ? ST_DIV : ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DIV: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else if (div_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result select and DIV sign fix-up; a zero divisor bypasses the fix-up entirely.
  always_comb begin
    hi_res_s = prod_q[2*DW-1:DW];
    lo_res_s = prod_q[DW-1:0];
    if (op_q[1]) begin
      if (b_q == {DW{1'b0}}) begin
        lo_res_s = {DW{1'b1}};
        hi_res_s = a_q;
      end else if (op_q == OP_DIV) begin
        lo_res_s = (a_q[DW-1] ^ b_q[DW-1]) ? neg_val(quot_s) : quot_s;
        hi_res_s = a_q[DW-1] ? neg_val(rem_s) : rem_s;
      end else begin
        lo_res_s = quot_s;
        hi_res_s = rem_s;
      end
    end else begin
      hi_res_s = prod_q[2*DW-1:DW];
      lo_res_s = prod_q[DW-1:0];
    end
  end

  // Registered outputs: done/wen pulse for one cycle, data holds the last result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_wen_q <= 2'b00;
      lo_wen_q <= 2'b00;
      hi_q     <= {DW{1'b0}};
      lo_q     <= {DW{1'b0}};
    end else begin
      busy_q   <= (state_d != ST_IDLE) || wr_s;
      done_q   <= wr_s;
      hi_wen_q <= wr_s ? 2'b11 : 2'b00;
      lo_wen_q <= wr_s ? 2'b11 : 2'b00;
      if (wr_s) begin
        hi_q <= hi_res_s;
        lo_q <= lo_res_s;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi_wen   = hi_wen_q;
  assign bus.lo_wen   = lo_wen_q;
  assign bus.hi_wdata = hi_q;
  assign bus.lo_wdata = lo_q;

endmodule
